// File: rtl/stream_demux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stream_demux_pkg                                           |
// | Description : Shared types, default parameters and select-check helper   |
// |               for the registered valid/ready stream demultiplexer.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package stream_demux_pkg;

  // Occupancy of one per-channel output slot
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_N_CH   = 4;
  localparam int unsigned DEF_SEL_W  = 2;
  localparam int unsigned DEF_CNT_W  = 8;

  // A select addresses a real channel only when it is below the channel count
  function automatic logic sel_valid(input int unsigned sel, input int unsigned n_ch);
    return (sel < n_ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_demux_slot.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stream_demux_slot                                          |
// | Description : One-entry output register for a single demux channel.      |
// |               Load wins over drain so a beat can replace the one being   |
// |               taken in the same cycle.                                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module stream_demux_slot
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  slot_state_e       state_q;
  logic [DATA_W-1:0] data_q;

  // Slot occupancy and held data; data only moves on a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else if (load_i) begin
      state_q <= SLOT_FULL;
      data_q  <= data_i;
    end else if ((state_q == SLOT_FULL) && ready_i) begin
      state_q <= SLOT_EMPTY;
    end
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/stream_demux_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stream_demux_reg                                           |
// | Description : Registered 1-to-N valid/ready demultiplexer. Each beat is  |
// |               parked in its channel's one-entry slot; beats whose select |
// |               names no channel are sunk and counted.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// SEL_W must be wide enough that 2**SEL_W >= N_CH.
module stream_demux_reg
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned N_CH   = DEF_N_CH,
  parameter int unsigned SEL_W  = DEF_SEL_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_W-1:0]      s_data,
  input  logic [SEL_W-1:0]       s_sel,
  output logic [N_CH-1:0]        m_valid,
  input  logic [N_CH-1:0]        m_ready,
  output logic [N_CH*DATA_W-1:0] m_data,
  output logic                   drop_pulse,
  output logic [CNT_W-1:0]       drop_cnt,
  input  logic                   drop_clr
);

  localparam int unsigned SEL_SPAN = 1 << SEL_W;

  logic                active_q;
  logic                drop_pulse_q;
  logic [CNT_W-1:0]    drop_cnt_d;
  logic [CNT_W-1:0]    drop_cnt_q;

  logic                w_sel_ok;
  logic                w_accept;
  logic                w_drop;
  logic [SEL_SPAN-1:0] w_valid_pad;
  logic [SEL_SPAN-1:0] w_mready_pad;
  logic [N_CH-1:0]     w_load;

  // Widen per-channel flags to the full select space so any s_sel indexes in range
  always_comb begin
    w_valid_pad              = '0;
    w_mready_pad             = '0;
    w_valid_pad[N_CH-1:0]    = m_valid;
    w_mready_pad[N_CH-1:0]   = m_ready;
  end

  assign w_sel_ok = sel_valid(32'(s_sel), N_CH);

  // Ready is blocked for the first edge after reset release so nothing is accepted then
  always_comb begin
    s_ready = 1'b0;
    if (active_q) begin
      if (w_sel_ok) begin
        s_ready = ~w_valid_pad[s_sel] | w_mready_pad[s_sel];
      end else begin
        s_ready = 1'b1;
      end
    end
  end

  assign w_accept = s_valid & s_ready;
  assign w_drop   = w_accept & ~w_sel_ok;

  // Marks the design live one clock after reset is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
    end
  end

  genvar k;
  generate
    for (k = 0; k < N_CH; k++) begin : g_slot
      assign w_load[k] = w_accept & w_sel_ok & (s_sel == SEL_W'(k));

      stream_demux_slot #(
        .DATA_W (DATA_W)
      ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (w_load[k]),
        .data_i  (s_data),
        .ready_i (m_ready[k]),
        .valid_o (m_valid[k]),
        .data_o  (m_data[k*DATA_W +: DATA_W])
      );
    end
  endgenerate

  // Clear beats increment; the counter sticks at all-ones
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_clr) begin
      drop_cnt_d = '0;
    end else if (w_drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // Drop pulse and saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      drop_pulse_q <= w_drop;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign drop_pulse = drop_pulse_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_stream_demux_reg                                        |
// | Description : Directed self-checking bench. Instance A uses the default  |
// |               4-channel configuration; instance B has 3 channels and a   |
// |               2-bit drop counter for invalid-select and saturation cases.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_stream_demux_reg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: DATA_W=8, N_CH=4, SEL_W=2, CNT_W=8
  logic        a_s_valid, a_s_ready, a_drop_pulse, a_drop_clr;
  logic [7:0]  a_s_data, a_drop_cnt;
  logic [1:0]  a_s_sel;
  logic [3:0]  a_m_valid, a_m_ready;
  logic [31:0] a_m_data;

  // Instance B: DATA_W=8, N_CH=3, SEL_W=2, CNT_W=2
  logic        b_s_valid, b_s_ready, b_drop_pulse, b_drop_clr;
  logic [7:0]  b_s_data;
  logic [1:0]  b_s_sel, b_drop_cnt;
  logic [2:0]  b_m_valid, b_m_ready;
  logic [23:0] b_m_data;

  int checks   = 0;
  int failures = 0;

  stream_demux_reg #(.DATA_W(8), .N_CH(4), .SEL_W(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_sel(a_s_sel),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
    .drop_pulse(a_drop_pulse), .drop_cnt(a_drop_cnt), .drop_clr(a_drop_clr)
  );

  stream_demux_reg #(.DATA_W(8), .N_CH(3), .SEL_W(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_sel(b_s_sel),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .drop_pulse(b_drop_pulse), .drop_cnt(b_drop_cnt), .drop_clr(b_drop_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step past the next rising edge; registered outputs are stable afterwards
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    a_s_valid  = 1'b1;
    a_s_sel    = 2'd0;
    a_s_data   = 8'h11;
    a_m_ready  = 4'hF;
    a_drop_clr = 1'b0;
    b_s_valid  = 1'b0;
    b_s_sel    = 2'd0;
    b_s_data   = 8'h00;
    b_m_ready  = 3'b000;
    b_drop_clr = 1'b0;

    // Reset held with a valid beat pending
    tick(); tick(); tick();
    chk("rst_m_valid",  64'(a_m_valid),    64'h0);
    chk("rst_m_data",   64'(a_m_data),     64'h0);
    chk("rst_drop_cnt", 64'(a_drop_cnt),   64'h0);
    chk("rst_pulse",    64'(a_drop_pulse), 64'h0);
    chk("rst_b_valid",  64'(b_m_valid),    64'h0);

    // Release: first edge accepts nothing, second edge accepts
    rst_n = 1'b1;
    tick();
    chk("rel_no_accept", 64'(a_m_valid), 64'h0);
    tick();
    chk("rel_accept_v", 64'(a_m_valid), 64'h1);
    chk("rel_accept_d", 64'(a_m_data[7:0]), 64'h11);

    // Routing: one beat per cycle to channels 0..3, all consumers ready
    for (int k = 0; k < 4; k++) begin
      a_s_sel  = 2'(k);
      a_s_data = 8'hA0 + 8'(k);
      #1;
      chk("route_ready", 64'(a_s_ready), 64'h1);
      tick();
      chk("route_valid", 64'(a_m_valid), 64'(4'b0001 << k));
      chk("route_data",  64'(a_m_data[k*8 +: 8]), 64'(8'hA0 + 8'(k)));
    end
    a_s_valid = 1'b0;
    tick();
    chk("route_drained", 64'(a_m_valid), 64'h0);
    chk("route_hold",    64'(a_m_data),  64'hA3A2A1A0);

    // Backpressure on channel 2
    a_m_ready = 4'b1011;
    a_s_valid = 1'b1;
    a_s_sel   = 2'd2;
    a_s_data  = 8'h55;
    #1;
    chk("bp_ready_first", 64'(a_s_ready), 64'h1);
    tick();
    chk("bp_valid1", 64'(a_m_valid), 64'b0100);
    chk("bp_data1",  64'(a_m_data[23:16]), 64'h55);
    a_s_data = 8'h66;
    #1;
    chk("bp_ready_blocked", 64'(a_s_ready), 64'h0);
    tick();
    chk("bp_held_valid", 64'(a_m_valid), 64'b0100);
    chk("bp_held_data",  64'(a_m_data[23:16]), 64'h55);
    a_m_ready = 4'hF;
    #1;
    chk("bp_ready_pass", 64'(a_s_ready), 64'h1);
    tick();
    chk("bp_valid2", 64'(a_m_valid), 64'b0100);
    chk("bp_data2",  64'(a_m_data[23:16]), 64'h66);
    a_s_valid = 1'b0;
    tick();
    chk("bp_empty", 64'(a_m_valid), 64'h0);
    chk("bp_idle_pulse", 64'(a_drop_pulse), 64'h0);

    // Invalid select on the 3-channel instance
    b_s_valid = 1'b1;
    b_s_sel   = 2'd3;
    b_s_data  = 8'h99;
    #1;
    chk("inv_ready", 64'(b_s_ready), 64'h1);
    tick();
    b_s_valid = 1'b0;
    chk("inv_pulse",   64'(b_drop_pulse), 64'h1);
    chk("inv_cnt",     64'(b_drop_cnt),   64'h1);
    chk("inv_m_valid", 64'(b_m_valid),    64'h0);
    tick();
    chk("inv_pulse_end", 64'(b_drop_pulse), 64'h0);
    chk("inv_cnt_hold",  64'(b_drop_cnt),   64'h1);

    // A valid beat on B stays parked with consumer stalled and does not count
    b_s_valid = 1'b1;
    b_s_sel   = 2'd1;
    b_s_data  = 8'h42;
    tick();
    b_s_valid = 1'b0;
    chk("b_load_valid", 64'(b_m_valid), 64'b010);
    chk("b_load_data",  64'(b_m_data[15:8]), 64'h42);
    chk("b_load_cnt",   64'(b_drop_cnt), 64'h1);
    chk("b_load_pulse", 64'(b_drop_pulse), 64'h0);

    // Saturation: four more drops (five total) on a 2-bit counter
    b_s_valid = 1'b1;
    b_s_sel   = 2'd3;
    tick(); tick();
    chk("sat_mid", 64'(b_drop_cnt), 64'h3);
    tick(); tick();
    chk("sat_top", 64'(b_drop_cnt), 64'h3);
    // Clear with a drop in the same cycle
    b_drop_clr = 1'b1;
    tick();
    chk("clr_cnt",   64'(b_drop_cnt),   64'h0);
    chk("clr_pulse", 64'(b_drop_pulse), 64'h1);
    b_drop_clr = 1'b0;
    b_s_valid  = 1'b0;
    tick();
    chk("clr_hold", 64'(b_drop_cnt), 64'h0);
    chk("clr_b_valid", 64'(b_m_valid), 64'b010);

    // Mid-operation reset with channels 0 and 1 full
    a_m_ready = 4'h0;
    a_s_valid = 1'b1;
    a_s_sel   = 2'd0;
    a_s_data  = 8'hC0;
    tick();
    a_s_sel   = 2'd1;
    a_s_data  = 8'hC1;
    tick();
    a_s_valid = 1'b0;
    chk("mid_full", 64'(a_m_valid), 64'b0011);
    chk("mid_data", 64'(a_m_data[15:0]), 64'hC1C0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_valid", 64'(a_m_valid), 64'h0);
    chk("mid_async_data",  64'(a_m_data),  64'h0);
    chk("mid_async_b",     64'(b_m_valid), 64'h0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("mid_after", 64'(a_m_valid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
